// File: rtl/mem_rd_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_rd_arbiter_pkg                                           |
// | Description : Shared constants and types for the memory read arbiter:     |
// |               default memory-port widths, requester ids, and the layout   |
// |               of one in-flight tag entry.                                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mem_rd_arbiter_pkg;

  // Default configuration of the shared memory read port
  localparam int c_nreq  = 2;
  localparam int c_depth = 4;
  localparam int c_aw    = 16;
  localparam int c_dw    = 16;

  // Requester ids; fetch sits at index 0 and therefore wins first after reset
  localparam int REQ_FETCH = 0;
  localparam int REQ_LD    = 1;

  // Width of the id field, never narrower than one bit
  function automatic int id_width(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  localparam int c_tag_id_w = id_width(c_nreq);

  // One in-flight read: who asked, and which address is expected back
  typedef struct packed {
    logic [c_tag_id_w-1:0] id;
    logic [c_aw-1:0]       addr;
  } tag_entry_t;

endpackage : mem_rd_arbiter_pkg
`default_nettype wire

// File: rtl/mem_rd_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_rd_arbiter_if                                            |
// | Description : Bus bundle between requesters, the arbiter and the memory.  |
// |   Requester side : req, req_addr (flattened, i at [i*AW +: AW]), gnt,      |
// |                    resp_valid (one-hot), resp_addr, resp_data             |
// |   Memory side    : mem_re, mem_raddr, mem_ready, mem_addr_out,            |
// |                    mem_data_out                                            |
// |   Modports       : slave  = arbiter view                                   |
// |                    master = requesters + memory model view                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface mem_rd_arbiter_if
  import mem_rd_arbiter_pkg::*;
#(
  parameter int NREQ = c_nreq,
  parameter int AW   = c_aw,
  parameter int DW   = c_dw
) ();

  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    resp_valid;
  logic [AW-1:0]      resp_addr;
  logic [DW-1:0]      resp_data;

  logic               mem_re;
  logic [AW-1:0]      mem_raddr;
  logic               mem_ready;
  logic [AW-1:0]      mem_addr_out;
  logic [DW-1:0]      mem_data_out;

  modport slave (
    input  req, req_addr, mem_ready, mem_addr_out, mem_data_out,
    output gnt, resp_valid, resp_addr, resp_data, mem_re, mem_raddr
  );

  modport master (
    output req, req_addr, mem_ready, mem_addr_out, mem_data_out,
    input  gnt, resp_valid, resp_addr, resp_data, mem_re, mem_raddr
  );

endinterface : mem_rd_arbiter_if
`default_nettype wire

// File: rtl/mem_rd_arbiter_tag_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_rd_arbiter_tag_fifo                                      |
// | Description : Synchronous FIFO holding in-flight read tags, oldest at the |
// |               head. Push and pop in the same cycle are allowed even when  |
// |               full. A separate occupancy counter tells full from empty.   |
// |   clk, rst    : clock, asynchronous active-high reset                      |
// |   i_push      : write i_push_data at the tail                              |
// |   i_pop       : drop the head entry                                        |
// |   o_head      : current head entry                                         |
// |   o_count     : occupancy, 0..DEPTH                                        |
// |   o_empty     : occupancy is zero                                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_rd_arbiter_tag_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty
);

  localparam int                c_ptr_w = $clog2(DEPTH);
  localparam logic [c_ptr_w:0]  c_full  = (c_ptr_w + 1)'(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w:0]   r_count;
  logic               w_do_push;
  logic               w_do_pop;

  // Guard against misuse so occupancy can never leave 0..DEPTH
  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != c_full) || w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; occupancy decides what is valid
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

endmodule : mem_rd_arbiter_tag_fifo
`default_nettype wire

// File: rtl/mem_rd_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_rd_arbiter                                               |
// | Description : Shares one memory read port among NREQ requesters. Grants   |
// |               one request per cycle round-robin, records each issued read |
// |               in an in-order tag FIFO and routes every in-order memory    |
// |               response back to the requester that issued it.             |
// |   clk         : clock, all state on posedge                                |
// |   reset       : asynchronous active-high reset                             |
// |   bus         : requester and memory signals (slave modport)               |
// |   outstanding : reads issued and not yet answered                          |
// |   err         : sticky, set when a response address misses the FIFO head |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_rd_arbiter
  import mem_rd_arbiter_pkg::*;
#(
  parameter int NREQ  = c_nreq,
  parameter int DEPTH = c_depth,
  parameter int AW    = c_aw,
  parameter int DW    = c_dw
) (
  input  logic                   clk,
  input  logic                   reset,
  mem_rd_arbiter_if.slave        bus,
  output logic [$clog2(DEPTH):0] outstanding,
  output logic                   err
);

  localparam int                 c_id_w     = id_width(NREQ);
  localparam int                 c_sum_w    = c_id_w + 1;
  localparam int                 c_cnt_w    = $clog2(DEPTH) + 1;
  localparam int                 c_ent_w    = c_id_w + AW;
  localparam logic [c_cnt_w-1:0] c_depth_n  = c_cnt_w'(DEPTH);
  localparam logic [c_sum_w-1:0] c_nreq_n   = c_sum_w'(NREQ);

  logic [AW-1:0]      w_req_addr [NREQ];
  logic [c_id_w-1:0]  r_rr_ptr;
  logic [c_sum_w-1:0] w_sum;
  logic [c_sum_w-1:0] w_sel_inc;
  logic [c_id_w-1:0]  w_sel;
  logic [c_id_w-1:0]  w_next_ptr;
  logic               w_found;
  logic               w_grant;
  logic               w_can_push;
  logic [NREQ-1:0]    w_gnt;

  logic [c_ent_w-1:0] w_head;
  logic [AW-1:0]      w_head_addr;
  logic [c_id_w-1:0]  w_head_id;
  logic [c_cnt_w-1:0] w_count;
  logic               w_empty;
  logic               w_hit;
  logic               w_pop;
  logic               w_mismatch;

  logic               r_mem_re;
  logic [AW-1:0]      r_mem_raddr;
  logic [NREQ-1:0]    r_resp_valid;
  logic [AW-1:0]      r_resp_addr;
  logic [DW-1:0]      r_resp_data;
  logic               r_err;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack_addr
      assign w_req_addr[gi] = bus.req_addr[gi*AW +: AW];
    end
  endgenerate

  // Response matching against the oldest in-flight read
  assign w_head_addr = w_head[AW-1:0];
  assign w_head_id   = w_head[AW +: c_id_w];
  assign w_hit       = bus.mem_ready && !w_empty;
  assign w_pop       = w_hit && (bus.mem_addr_out == w_head_addr);
  assign w_mismatch  = w_hit && (bus.mem_addr_out != w_head_addr);

  // A pop in the same cycle frees a slot, so a full FIFO can still accept
  assign w_can_push  = (w_count < c_depth_n) || w_pop;

  // Round-robin: walk offsets from the highest down so the smallest offset
  // from the pointer with an active request is the one left in w_sel.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_sum   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_rr_ptr} + c_sum_w'(k);
      if (w_sum >= c_nreq_n) w_sum = w_sum - c_nreq_n;
      if (bus.req[w_sum[c_id_w-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_sum[c_id_w-1:0];
      end
    end
  end

  assign w_grant    = w_found && w_can_push;
  assign w_sel_inc  = {1'b0, w_sel} + 1'b1;
  assign w_next_ptr = (w_sel_inc == c_nreq_n) ? '0 : w_sel_inc[c_id_w-1:0];

  always_comb begin
    w_gnt = '0;
    if (w_grant) w_gnt[w_sel] = 1'b1;
  end

  mem_rd_arbiter_tag_fifo #(
    .WIDTH (c_ent_w),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk         (clk),
    .rst         (reset),
    .i_push      (w_grant),
    .i_push_data ({w_sel, w_req_addr[w_sel]}),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_empty     (w_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem_re     <= 1'b0;
      r_mem_raddr  <= '0;
      r_rr_ptr     <= c_id_w'(REQ_FETCH);
      r_resp_valid <= '0;
      r_resp_addr  <= '0;
      r_resp_data  <= '0;
      r_err        <= 1'b0;
    end else begin
      r_mem_re <= w_grant;
      if (w_grant) begin
        r_mem_raddr <= w_req_addr[w_sel];
        r_rr_ptr    <= w_next_ptr;
      end
      r_resp_valid <= w_pop ? (NREQ'(1) << w_head_id) : '0;
      if (w_pop) begin
        r_resp_addr <= bus.mem_addr_out;
        r_resp_data <= bus.mem_data_out;
      end
      // Responses with an empty FIFO are strays and never flag an error
      if (w_mismatch) r_err <= 1'b1;
    end
  end

  assign bus.gnt        = w_gnt;
  assign bus.mem_re     = r_mem_re;
  assign bus.mem_raddr  = r_mem_raddr;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_addr  = r_resp_addr;
  assign bus.resp_data  = r_resp_data;
  assign outstanding    = w_count;
  assign err            = r_err;

endmodule : mem_rd_arbiter
`default_nettype wire

// File: tb/tb_mem_rd_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_rd_arbiter                                            |
// | Description : Scoreboard bench for mem_rd_arbiter. A reference model built |
// |               from queues predicts grants, issue, occupancy and errors;   |
// |               expected responses are queued at the time of the pop and a  |
// |               separate monitor matches them against resp_valid pulses.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mem_rd_arbiter;
  import mem_rd_arbiter_pkg::*;

  localparam int NREQ  = 2;
  localparam int DEPTH = 4;
  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [CW-1:0] outstanding;
  logic          err;

  always #5 clk = ~clk;

  mem_rd_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  mem_rd_arbiter #(
    .NREQ  (NREQ),
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .outstanding (outstanding),
    .err         (err)
  );

  typedef struct {
    logic [NREQ-1:0] vld;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   data;
    int              due;
  } resp_t;

  tag_entry_t    model_q [$];
  resp_t         exp_q   [$];
  logic [AW-1:0] mem_pend[$];
  int            model_ptr;
  bit            model_err;
  logic          exp_mem_re;
  logic [AW-1:0] exp_mem_raddr;
  bit            cur_req  [NREQ];
  logic [AW-1:0] cur_addr [NREQ];
  int            last_gnt;
  int            cyc = 0;
  bit            started = 1'b0;
  int            checks = 0;
  int            failures = 0;
  resp_t         mon_r;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
    return (a * 16'd3) ^ 16'h5A5A;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int id);
    logic [NREQ-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    model_q.delete();
    exp_q.delete();
    model_ptr     = 0;
    model_err     = 1'b0;
    exp_mem_re    = 1'b0;
    exp_mem_raddr = '0;
    last_gnt      = -1;
    for (int i = 0; i < NREQ; i++) cur_req[i] = 1'b0;
  endtask

  // Called at posedge+1: update requesters and memory, then drive the bus.
  task automatic drive(input int req_pct, input int rsp_pct, input bit bad_addr, input bit sticky);
    for (int i = 0; i < NREQ; i++) begin
      if (last_gnt == i && !sticky) cur_req[i] = 1'b0;
      if (!cur_req[i] && ($urandom_range(0, 99) < req_pct)) begin
        cur_req[i]  = 1'b1;
        cur_addr[i] = 16'h0100 + 16'(16 * $urandom_range(0, 5));
      end
    end
    bus.mem_ready    = 1'b0;
    bus.mem_addr_out = AW'($urandom);
    bus.mem_data_out = DW'($urandom);
    if (mem_pend.size() > 0 && ($urandom_range(0, 99) < rsp_pct)) begin
      bus.mem_ready    = 1'b1;
      bus.mem_addr_out = bad_addr ? mem_pend[0] + 16'h0004 : mem_pend[0];
      bus.mem_data_out = mem_data(bus.mem_addr_out);
      if (!bad_addr) void'(mem_pend.pop_front());
    end
    // A read issued this cycle can be answered from the next cycle on
    if (bus.mem_re) mem_pend.push_back(bus.mem_raddr);
    for (int i = 0; i < NREQ; i++) begin
      bus.req[i]               = cur_req[i];
      bus.req_addr[i*AW +: AW] = cur_addr[i];
    end
  endtask

  // Predict this cycle at the negedge, advance the model, check after the edge.
  task automatic step();
    logic [NREQ-1:0] exp_gnt;
    tag_entry_t      te;
    bit              pop;
    bit              mism;
    int              g;
    @(negedge clk);
    pop  = bus.mem_ready && (model_q.size() > 0) && (bus.mem_addr_out == model_q[0].addr);
    mism = bus.mem_ready && (model_q.size() > 0) && !pop;
    g    = -1;
    if (model_q.size() < DEPTH || pop) begin
      for (int k = 0; k < NREQ; k++) begin
        if (g < 0 && cur_req[(model_ptr + k) % NREQ]) g = (model_ptr + k) % NREQ;
      end
    end
    exp_gnt = (g >= 0) ? onehot(g) : '0;
    chk("gnt", 32'(bus.gnt), 32'(exp_gnt));
    if (pop) begin
      exp_q.push_back('{onehot(int'(model_q[0].id)), bus.mem_addr_out, bus.mem_data_out, cyc + 1});
      void'(model_q.pop_front());
    end
    if (mism) model_err = 1'b1;
    exp_mem_re = (g >= 0);
    if (g >= 0) begin
      te.id   = c_tag_id_w'(g);
      te.addr = cur_addr[g];
      model_q.push_back(te);
      exp_mem_raddr = cur_addr[g];
      model_ptr     = (g + 1) % NREQ;
    end
    last_gnt = g;
    @(posedge clk);
    #1;
    chk("mem_re", 32'(bus.mem_re), 32'(exp_mem_re));
    chk("mem_raddr", 32'(bus.mem_raddr), 32'(exp_mem_raddr));
    chk("outstanding", 32'(outstanding), model_q.size());
    chk("err", 32'(err), 32'(model_err));
  endtask

  task automatic drain();
    for (int i = 0; i < NREQ; i++) cur_req[i] = 1'b0;
    repeat (12) begin
      drive(0, 100, 1'b0, 1'b0);
      step();
    end
  endtask

  // Scoreboard monitor: every resp_valid pulse must match the oldest expected
  // response, and no expected response may pass its due cycle unseen.
  always @(negedge clk) begin
    if (started && !reset) begin
      if (bus.resp_valid != '0) begin
        if (exp_q.size() == 0) begin
          chk("resp_unexpected", 32'(bus.resp_valid), 32'd0);
        end else begin
          mon_r = exp_q.pop_front();
          chk("resp_cycle", cyc, mon_r.due);
          chk("resp_valid", 32'(bus.resp_valid), 32'(mon_r.vld));
          chk("resp_addr", 32'(bus.resp_addr), 32'(mon_r.addr));
          chk("resp_data", 32'(bus.resp_data), 32'(mon_r.data));
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        chk("resp_missing", 32'(bus.resp_valid), 32'(exp_q[0].vld));
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    reset            = 1'b1;
    bus.req          = '0;
    bus.req_addr     = '0;
    bus.mem_ready    = 1'b0;
    bus.mem_addr_out = '0;
    bus.mem_data_out = '0;
    for (int i = 0; i < NREQ; i++) cur_addr[i] = '0;
    model_reset();
    #12;
    chk("rst_mem_re", 32'(bus.mem_re), 32'd0);
    chk("rst_mem_raddr", 32'(bus.mem_raddr), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_addr", 32'(bus.resp_addr), 32'd0);
    chk("rst_resp_data", 32'(bus.resp_data), 32'd0);
    chk("rst_outstanding", 32'(outstanding), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    started = 1'b1;

    // Single request from the fetch port
    cur_req[REQ_FETCH]  = 1'b1;
    cur_addr[REQ_FETCH] = 16'h0040;
    drive(0, 0, 1'b0, 1'b0);
    step();
    repeat (4) begin
      drive(0, 100, 1'b0, 1'b0);
      step();
    end

    // Contention with both requests held on fixed addresses
    cur_req[REQ_FETCH]  = 1'b1;
    cur_addr[REQ_FETCH] = 16'h0010;
    cur_req[REQ_LD]     = 1'b1;
    cur_addr[REQ_LD]    = 16'h0020;
    repeat (8) begin
      drive(0, 100, 1'b0, 1'b1);
      step();
    end

    // Fill to DEPTH with no responses, then respond while still requesting
    repeat (6) begin
      drive(0, 0, 1'b0, 1'b1);
      step();
    end
    repeat (4) begin
      drive(0, 100, 1'b0, 1'b1);
      step();
    end
    drain();

    // Randomized traffic with duplicate addresses from a small pool
    repeat (400) begin
      drive(40, 60, 1'b0, 1'b0);
      step();
    end
    drain();

    // Address mismatch at the head sets a sticky error
    cur_req[REQ_FETCH]  = 1'b1;
    cur_addr[REQ_FETCH] = 16'h0300;
    drive(0, 0, 1'b0, 1'b0);
    step();
    drive(0, 0, 1'b0, 1'b0);
    step();
    repeat (2) begin
      drive(0, 100, 1'b1, 1'b0);
      step();
    end
    drain();

    // Reset with two reads in flight while mem_re is high
    cur_req[REQ_FETCH]  = 1'b1;
    cur_addr[REQ_FETCH] = 16'h0500;
    cur_req[REQ_LD]     = 1'b1;
    cur_addr[REQ_LD]    = 16'h0600;
    drive(0, 0, 1'b0, 1'b0);
    step();
    drive(0, 0, 1'b0, 1'b0);
    step();
    #3;
    reset = 1'b1;
    #1;
    chk("async_rst_mem_re", 32'(bus.mem_re), 32'd0);
    chk("async_rst_outstanding", 32'(outstanding), 32'd0);
    chk("async_rst_err", 32'(err), 32'd0);
    chk("async_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    model_reset();
    bus.req       = '0;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    // Stale responses now arrive with the FIFO empty and must be dropped
    repeat (6) begin
      drive(0, 100, 1'b0, 1'b0);
      step();
    end
    drain();

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mem_rd_arbiter
`default_nettype wire

// File: doc/mem_rd_arbiter.md
Name: mem_rd_arbiter

Overview:
- Shares the single memory read port (raddr/re in; addr_out/data_out/ready back) between NREQ requesters, e.g. instruction fetch and one or more ld units.
- Grants one request per cycle using round-robin.
- Tracks in-flight reads in an in-order tag FIFO and routes each memory response back to the requester that issued it.
- Sits between the requesters and the memory model; the memory returns responses in issue order, tagged by address.

Parameters:
- NREQ, 2, number of requesters (index 0 = highest priority after reset).
- DEPTH, 4, maximum outstanding reads (power of 2).
- AW, 16, address width.
- DW, 16, data width.

Ports:
- clk  in  1  clock, all state on posedge.
- reset  in  1  asynchronous active-high reset.
- req  in  NREQ  per-requester read request, level; held until granted.
- req_addr  in  NREQ*AW  flattened addresses; requester i at [i*AW +: AW].
- gnt  out  NREQ  combinational one-hot grant for this cycle.
- resp_valid  out  NREQ  registered one-hot response strobe.
- resp_addr  out  AW  address of delivered response.
- resp_data  out  DW  data of delivered response.
- mem_re  out  1  registered read enable to memory.
- mem_raddr  out  AW  registered read address.
- mem_ready  in  1  memory response valid.
- mem_addr_out  in  AW  response address tag.
- mem_data_out  in  DW  response data.
- outstanding  out  $clog2(DEPTH)+1  current FIFO occupancy.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (async, any time) clears the following:
  - mem_re=0, mem_raddr=0, resp_valid=0, resp_addr=0, resp_data=0, err=0.
  - FIFO empty, outstanding=0.
  - Round-robin pointer=0, so requester 0 has priority first.
- Reset mid-flight discards all in-flight entries. Responses that arrive afterwards while the FIFO is empty are dropped silently; see the stray rule below.
- Arbitration (combinational, cycle t):
  - Starting at pointer p, pick the first i (wrapping modulo NREQ) with req[i]=1.
  - gnt[i]=1 only if can_push, where can_push = (outstanding<DEPTH) || pop_this_cycle.
  - At most one gnt bit is high at a time.
- Issue (posedge ending cycle t, on grant):
  - mem_re<=1, mem_raddr<=req_addr[i].
  - Push {id=i, addr} into the FIFO.
  - p<=(i+1) mod NREQ.
  - With no grant: mem_re<=0, mem_raddr holds, p holds.
  - Requester i sees gnt[i] in cycle t and must deassert or present its next request from t+1. Issue latency is 1 cycle (mem_re high in t+1).
- Response matching, when mem_ready=1:
  - FIFO non-empty and mem_addr_out==head.addr: pop. At the next edge resp_valid[head.id]<=1, resp_addr<=mem_addr_out, resp_data<=mem_data_out. Response latency is 1 cycle after mem_ready.
  - FIFO non-empty and addr mismatch: no pop, err<=1 (sticky until reset), resp_valid stays 0.
  - FIFO empty: stray response; dropped, no err.
- resp_valid is a single-cycle pulse; otherwise all bits are 0. resp_addr/resp_data hold their last delivered value.
- Simultaneous push and pop in one cycle is legal, including when the FIFO is full; occupancy is unchanged.
- outstanding = pushes - pops; it never exceeds DEPTH and never goes negative.
- FIFO pointers wrap modulo DEPTH; a separate occupancy counter disambiguates full from empty.
- Duplicate addresses in flight are legal. In-order matching assigns responses FIFO-head first.
- Same requester granted in consecutive cycles is allowed only if it is the only requester asserting req.

Decomposition:
- Shared package/include holds:
  - Memory-port width constants (AW, DW).
  - Requester id constants: REQ_FETCH=0, REQ_LD=1.
  - FIFO entry layout (id field width $clog2(NREQ), addr field).
- One natural sub-module: tag_fifo, a synchronous FIFO.
  - Parameters: width, depth.
  - Ports: push/pop, head, count, async reset.
  - Instantiated once for the in-flight tags.
- Round-robin selection stays inline.

Test Plan:
- Single request: req=01, addr0=0x0040 → gnt=01 same cycle; next cycle mem_re=1, mem_raddr=0x0040. Memory returns ready, addr 0x0040, data 0xBEEF → one cycle later resp_valid=01, resp_data=0xBEEF, outstanding 1→0.
- Contention: req=11 held continuously, addr0=0x0010, addr1=0x0020 → grants alternate 01,10,01,10. mem_raddr sequence is 0x0010,0x0020,0x0010,0x0020.
- Full backpressure (DEPTH=4): 4 grants with no responses → outstanding=4, gnt=00 while req held. A matching response in cycle t → gnt asserted in the same cycle t, and outstanding stays 4.
- Routing: issue 0x0100 (req 1) then 0x0200 (req 0); responses arrive in order → resp_valid=10 with data for 0x0100, then resp_valid=01 with data for 0x0200.
- Mismatch: head addr 0x0300, memory returns ready with addr 0x0304 → err=1, no resp_valid, outstanding unchanged. err stays 1 until reset.
- Reset mid-flight: 2 outstanding, assert reset → immediately mem_re=0, outstanding=0. Later response for an old address → dropped, err=0, resp_valid=00.
